seg7_scan_sched: RTL and testbench

- Time-multiplexing scheduler for the shared 4-digit 7-segment display: one `seg` bus, four anodes.
- Shares the segment bus between the four digit positions in round-robin time slots.
- Inserts a blanking gap at each slot start to prevent ghosting.
- Accepts new display values from an upstream counter/FSM via a valid/ready handshake, committed only at frame boundaries so a frame never shows mixed old and new values.

---
 rtl/seg7_scan_sched_pkg.sv | 40 ++++
 rtl/seg7_scan_sched_if.sv | 10 +
 rtl/seg7_scan_sched_bcd_decoder.sv | 9 +
 rtl/seg7_scan_sched.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_sched.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_sched_pkg.sv
// Shared constants and BCD-to-segment encoding for the 4-digit display scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} scan_state_e;

  // Non-decimal nibbles render as a dash so bad data is visible, not misleading.
  function automatic logic [6:0] encode_bcd(input logic [3:0] nibble);
    logic [6:0] code;
    case (nibble)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_scan_sched_if.sv
// Upstream valid/ready load channel carrying a new 4-digit value and its decimal points.
interface seg7_scan_sched_if;
  logic        load;
  logic        load_ready;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;

  modport master (output load, output digits_in, output dp_in, input load_ready);
  modport slave  (input load, input digits_in, input dp_in, output load_ready);
endinterface

// File: rtl/seg7_scan_sched_bcd_decoder.sv
// Combinational BCD digit to active-low segment pattern decoder.
module seg7_bcd_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = encode_bcd(bcd);
endmodule

// File: rtl/seg7_scan_sched.sv
// Round-robin scan scheduler for a shared-bus 4-digit 7-segment display with
// per-slot blanking, leading-zero suppression and frame-aligned value commit.
module seg7_scan_sched
  import seg7_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int CNT_W     = 17
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_sched_if.slave    up,
  input  logic [3:0]          en_mask,
  input  logic                lz_suppress,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [3:0]          an_out,
  output logic                frame_start
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  scan_state_e      state_q, state_d;
  logic [15:0]      active_digits_q, active_digits_d;
  logic [3:0]       active_dp_q, active_dp_d;
  logic [15:0]      pend_digits_q, pend_digits_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pend_valid_q, pend_valid_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic             frame_start_q, frame_start_d;

  logic             wrap_s;
  logic [3:0]       cur_digit_s;
  logic [6:0]       dec_seg_s;
  logic [3:0]       zero_s;
  logic [3:0]       supp_s;
  logic [3:0]       an_sel_s;

  assign up.load_ready = ~pend_valid_q;
  assign cur_digit_s   = active_digits_q[{idx_q, 2'b00} +: 4];
  assign an_sel_s      = ~(4'b0001 << idx_q);

  seg7_bcd_decoder u_dec (
    .bcd (cur_digit_s),
    .seg (dec_seg_s)
  );

  // Slot timing, commit/capture of display buffers and next-state FSM.
  always_comb begin
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    active_digits_d = active_digits_q;
    active_dp_d     = active_dp_q;
    pend_digits_d   = pend_digits_q;
    pend_dp_d       = pend_dp_q;
    pend_valid_d    = pend_valid_q;
    wrap_s          = (cnt_q == CNT_LAST);

    if (wrap_s) begin
      cnt_d = CNT_ZERO;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Commit only on the 3->0 boundary so a frame never mixes two values.
    if (wrap_s && (idx_q == 2'd3) && pend_valid_q) begin
      active_digits_d = pend_digits_q;
      active_dp_d     = pend_dp_q;
      pend_valid_d    = 1'b0;
    end else if (up.load && !pend_valid_q) begin
      pend_digits_d = up.digits_in;
      pend_dp_d     = up.dp_in;
      pend_valid_d  = 1'b1;
    end else begin
      pend_valid_d  = pend_valid_q;
    end

    state_d       = (cnt_d < BLANK_END) ? ST_BLANK : ST_DRIVE;
    frame_start_d = (cnt_q == CNT_ZERO) && (idx_q == 2'd0);
  end

  // Leading-zero mask: a digit is suppressed only if it and every digit left of it is zero.
  always_comb begin
    zero_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      zero_s[i] = (active_digits_q[i*4 +: 4] == 4'd0);
    end
    if (lz_suppress) begin
      supp_s = {zero_s[3], zero_s[3] & zero_s[2], zero_s[3] & zero_s[2] & zero_s[1], 1'b0};
    end else begin
      supp_s = 4'b0000;
    end
  end

  // Output pattern for the current slot; suppressed digits still light a set dp.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = AN_OFF;
    if ((state_q == ST_DRIVE) && en_mask[idx_q]) begin
      if (supp_s[idx_q]) begin
        if (active_dp_q[idx_q]) begin
          an_d = an_sel_s;
          dp_d = 1'b0;
        end else begin
          an_d = AN_OFF;
        end
      end else begin
        an_d  = an_sel_s;
        seg_d = dec_seg_s;
        dp_d  = ~active_dp_q[idx_q];
      end
    end else begin
      an_d = AN_OFF;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q           <= CNT_ZERO;
      idx_q           <= 2'd0;
      state_q         <= ST_BLANK;
      active_digits_q <= 16'h0000;
      active_dp_q     <= 4'b0000;
      pend_digits_q   <= 16'h0000;
      pend_dp_q       <= 4'b0000;
      pend_valid_q    <= 1'b0;
      seg_q           <= SEG_OFF;
      dp_q            <= 1'b1;
      an_q            <= AN_OFF;
      frame_start_q   <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      state_q         <= state_d;
      active_digits_q <= active_digits_d;
      active_dp_q     <= active_dp_d;
      pend_digits_q   <= pend_digits_d;
      pend_dp_q       <= pend_dp_d;
      pend_valid_q    <= pend_valid_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      an_q            <= an_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an_out      = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_sched.sv
// Directed, table-driven bench for seg7_scan_sched with a 10-cycle slot and 2 blank cycles.
module tb_seg7_scan_sched;
  import seg7_pkg::*;

  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0]      dpv;
    logic [3:0]      en;
    logic            lz;
    logic [3:0][3:0] an;
    logic [3:0][6:0] sg;
    logic [3:0]      dpo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] en_mask = 4'b1111;
  logic       lz_suppress = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an_out;
  logic       frame_start;
  int         n_pass = 0;
  int         n_total = 0;
  vec_t       vecs[7];
  vec_t       vz;

  seg7_scan_sched_if up_if ();

  seg7_scan_sched #(.TICK_DIV(10), .BLANK_CYC(2), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .up          (up_if),
    .en_mask     (en_mask),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dp          (dp),
    .an_out      (an_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {16'h0, an_out, seg, dp, frame_start, up_if.load_ready},
        {16'h0, 4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b1});
  endtask

  task automatic wait_fs(input string name, output bit ok);
    int n = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    if (frame_start === 1'b1) ok = 1'b1;
    else chk({name, "_fs_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_commit(input string name);
    int n = 0;
    while (up_if.load_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (up_if.load_ready !== 1'b1) chk({name, "_commit_timeout"}, 32'd0, 32'd1);
  endtask

  // Drives one load pulse at a negedge once ready; checks ready falls afterwards.
  task automatic load_value(input string name, input logic [15:0] d, input logic [3:0] p);
    int n = 0;
    while (up_if.load_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    up_if.digits_in = d;
    up_if.dp_in     = p;
    up_if.load      = 1'b1;
    @(negedge clk);
    up_if.load      = 1'b0;
    chk({name, "_ready_fall"}, {31'd0, up_if.load_ready}, 32'd0);
  endtask

  // Checks one full 40-cycle frame from its frame_start plus the next frame_start.
  task automatic check_frame(input string name, input vec_t v);
    bit ok;
    logic [12:0] exp;
    int slot, c;
    wait_fs(name, ok);
    if (ok) begin
      for (int k = 0; k <= 40; k++) begin
        if (k > 0) @(negedge clk);
        if (k == 40) begin
          chk({name, "_period"}, {31'd0, frame_start}, 32'd1);
        end else begin
          slot = k / 10;
          c    = k % 10;
          if (c < 2) exp = {4'b1111, 7'b1111111, 1'b1, (k == 0)};
          else       exp = {v.an[slot], v.sg[slot], v.dpo[slot], 1'b0};
          chk($sformatf("%s_k%0d", name, k), {19'd0, an_out, seg, dp, frame_start}, {19'd0, exp});
        end
      end
    end
  endtask

  initial begin
    bit ok;
    up_if.load      = 1'b0;
    up_if.digits_in = 16'h0000;
    up_if.dp_in     = 4'b0000;

    vz      = '{digits:16'h0000, dpv:4'b0000, en:4'b1111, lz:1'b0,
                an:{4'b0111, 4'b1011, 4'b1101, 4'b1110},
                sg:{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, dpo:4'b1111};
    vecs[0] = '{digits:16'h1234, dpv:4'b0000, en:4'b1111, lz:1'b0,
                an:{4'b0111, 4'b1011, 4'b1101, 4'b1110},
                sg:{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, dpo:4'b1111};
    vecs[1] = '{digits:16'h0007, dpv:4'b0000, en:4'b1111, lz:1'b1,
                an:{4'b1111, 4'b1111, 4'b1111, 4'b1110},
                sg:{7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}, dpo:4'b1111};
    vecs[2] = '{digits:16'h0000, dpv:4'b0000, en:4'b1111, lz:1'b1,
                an:{4'b1111, 4'b1111, 4'b1111, 4'b1110},
                sg:{7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, dpo:4'b1111};
    vecs[3] = '{digits:16'h00A0, dpv:4'b0000, en:4'b1011, lz:1'b0,
                an:{4'b0111, 4'b1111, 4'b1101, 4'b1110},
                sg:{7'b1000000, 7'b1111111, 7'b0111111, 7'b1000000}, dpo:4'b1111};
    vecs[4] = '{digits:16'h0080, dpv:4'b0100, en:4'b1111, lz:1'b1,
                an:{4'b1111, 4'b1011, 4'b1101, 4'b1110},
                sg:{7'b1111111, 7'b1111111, 7'b0000000, 7'b1000000}, dpo:4'b1011};
    vecs[5] = '{digits:16'h9A05, dpv:4'b0001, en:4'b1111, lz:1'b0,
                an:{4'b0111, 4'b1011, 4'b1101, 4'b1110},
                sg:{7'b0010000, 7'b0111111, 7'b1000000, 7'b0010010}, dpo:4'b1110};
    vecs[6] = '{digits:16'h0600, dpv:4'b0000, en:4'b1111, lz:1'b1,
                an:{4'b1111, 4'b1011, 4'b1101, 4'b1110},
                sg:{7'b1111111, 7'b0000010, 7'b1000000, 7'b1000000}, dpo:4'b1111};

    // Reset held for 5 cycles, then the first frame shows all zeros.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_reset_outputs($sformatf("reset_hold%0d", i));
    end
    rst = 1'b1;
    check_frame("post_reset", vz);

    // Load 1234, then a second load while pending must be ignored.
    en_mask     = vecs[0].en;
    lz_suppress = vecs[0].lz;
    load_value("v0", vecs[0].digits, vecs[0].dpv);
    up_if.digits_in = 16'h5678;
    up_if.load      = 1'b1;
    @(negedge clk);
    up_if.load      = 1'b0;
    chk("ignored_load_ready", {31'd0, up_if.load_ready}, 32'd0);
    wait_commit("v0");
    check_frame("v0_a", vecs[0]);
    chk("v0_ready_after", {31'd0, up_if.load_ready}, 32'd1);
    check_frame("v0_b", vecs[0]);

    for (int i = 1; i < 7; i++) begin
      en_mask     = vecs[i].en;
      lz_suppress = vecs[i].lz;
      load_value($sformatf("v%0d", i), vecs[i].digits, vecs[i].dpv);
      wait_commit($sformatf("v%0d", i));
      check_frame($sformatf("v%0d", i), vecs[i]);
    end

    // Reset mid-DRIVE of slot 2 with a value pending; pending must be discarded.
    en_mask     = 4'b1111;
    lz_suppress = 1'b0;
    wait_fs("pre_rst", ok);
    load_value("rst_load", 16'h5678, 4'b1111);
    repeat (23) @(negedge clk);
    chk("rst_pending", {28'd0, up_if.load_ready, an_out}, {28'd0, 1'b0, 4'b1011});
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst = 1'b1;
    check_frame("after_rst_a", vz);
    check_frame("after_rst_b", vz);
    chk("after_rst_ready", {31'd0, up_if.load_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
